tm1638_responder: RTL and testbench
===================================

TM1638_RESPONDER -- requirements
Module: tm1638_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops on stb/clk/dio (≥2).
REQ-002 SHALL have port CLK  input  1  system clock, single clock domain; sysclock ≥ 8× serial clock.
REQ-003 SHALL have port RESET_  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port tm_stb  input  1  TM1638 strobe from host, active-low frame delimiter.
REQ-005 SHALL have port tm_clk  input  1  TM1638 serial clock from host.
REQ-006 SHALL have port dio_in  input  1  sampled serial data line.
REQ-007 SHALL have port dio_out  output  1  serial data driven toward host.
REQ-008 SHALL have port dio_oe  output  1  high = drive dio_out onto the line; tristate buffer sits in the top level.
REQ-009 SHALL have port keys  input  8  key states, bit 0 = leftmost.
REQ-010 SHALL have port disp_ram  output  128  display RAM, byte n at bits [8n+7:8n].
REQ-011 SHALL have port display_on  output  1  display-control on bit.
REQ-012 SHALL have port brightness  output  3  display-control brightness.
REQ-013 SHALL have port frame_error  output  1  one-cycle pulse on a malformed frame.

Function
REQ-014 SHALL synchronize tm_stb, tm_clk and dio_in, then detect tm_clk rising/falling and tm_stb falling/rising edges on the synchronized signals.
REQ-015 SHALL shift dio_in LSB-first on each tm_clk rising edge while tm_stb is low, using a 3-bit bit counter.
REQ-016 SHALL run FSM states IDLE, CMD, WDATA, RDATA, SKIP.
REQ-017 SHALL enter CMD from IDLE on a tm_stb falling edge.
REQ-018 SHALL decode the first complete byte in CMD by bits[7:6]:
  - 01 data command: store bit1 (read) and bit2 (fixed address); read=1 -> RDATA, else SKIP.
  - 10 display control: display_on <= bit3, brightness <= bits[2:0]; -> SKIP.
  - 11 address set: address <= bits[3:0]; -> WDATA.
  - 00: pulse frame_error; -> SKIP.
REQ-019 SHALL, in WDATA, write each complete byte to disp_ram[address] one cycle after the 8th rising edge; then increment address modulo 16 (0xF wraps to 0x0) unless fixed mode is set.
REQ-020 SHALL, in RDATA, present on each tm_clk falling edge the next bit of key bytes 0..3, LSB-first, starting with the first falling edge after the command byte.
REQ-021 Key byte n SHALL be: bit0 = keys[n], bit4 = keys[n+4], all other bits 0.
REQ-022 SHALL hold dio_oe high from the first RDATA falling edge until the tm_clk rising edge that samples bit 31; it SHALL then drop dio_oe, go to SKIP, and ignore dio_in throughout RDATA.
REQ-023 SHALL ignore all bits in SKIP until tm_stb rises.
REQ-024 SHALL, on a tm_stb rising edge in any state, go to IDLE and clear the bit counter and dio_oe.
REQ-025 SHALL pulse frame_error when tm_stb rises with a non-zero bit counter, or during RDATA before 32 bits; the partial byte is discarded.
REQ-026 SHALL persist the data-command mode across frames.
REQ-027 SHALL give a tm_stb edge priority over a tm_clk edge detected in the same cycle.
REQ-028 SHALL ignore tm_clk edges while tm_stb is high.

Reset
REQ-029 SHALL, on RESET_ low, force: state IDLE, disp_ram all 0, display_on 0, brightness 0, address 0, mode write/auto-increment, dio_oe 0, dio_out 1, frame_error 0, and the synchronizers to idle-high.
REQ-030 SHALL abandon any frame in progress when RESET_ asserts mid-frame; it SHALL wait for the next tm_stb falling edge after release.

Structure
REQ-031 SHALL place the command-field constants (data, display, address, read bit, fixed bit) in shared package tm1638_pkg, which tm1638_driver also uses.
REQ-032 SHALL instantiate one sub-module, tm1638_sync_edge (synchronizer plus edge detect), three times.

Verification
REQ-033 Frame 0x40; frame 0xC0,0x3F,0x06,0x5B -> disp_ram bytes 0..2 = 0x3F,0x06,0x5B; others 0.
REQ-034 Frame 0x44; frame 0xCF,0x11,0x22 -> byte 15 = 0x22, byte 0 unchanged; then auto mode with 0xCF,0xAA,0xBB -> byte 15 = 0xAA, byte 0 = 0xBB (wrap).
REQ-035 keys = 0x81; frame 0x42 plus 32 clocks -> host reads 0x01,0x00,0x00,0x10; dio_oe low after bit 31.
REQ-036 Frame 0x8F -> display_on = 1, brightness = 7; frame 0x80 -> display_on = 0, brightness = 0.
REQ-037 tm_stb rises after 5 bits of a data byte -> frame_error pulses once and disp_ram is unchanged.
REQ-038 RESET_ asserted mid-RDATA -> dio_oe = 0 within one cycle; a following frame 0xC1,0x77 -> byte 1 = 0x77.

Source files
------------

// File: rtl/tm1638_pkg.sv
// tm1638_pkg: command-field constants, FSM states and key-scan packing shared by the
// TM1638 responder and driver.
package tm1638_pkg;
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_DISP = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;
  localparam int READ_BIT  = 1;
  localparam int FIXED_BIT = 2;
  localparam int ON_BIT    = 3;
  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, SKIP} state_e;
  function automatic logic [31:0] key_word(input logic [7:0] k);
    key_word = '0;
    for (int n = 0; n < 4; n++) begin
      key_word[8*n]   = k[n];
      key_word[8*n+4] = k[n+4];
    end
  endfunction
endpackage

// File: rtl/tm1638_sync_edge.sv
// tm1638_sync_edge: multi-flop synchronizer with rise/fall detect; resets to idle-high
// so a line that is already high after reset produces no spurious edge.
module tm1638_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RESET_,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;
endmodule

// File: rtl/tm1638_responder.sv
// tm1638_responder: TM1638 slave emulation -- decodes host commands, holds the 16-byte
// display RAM and display control, and shifts out the key scan on read frames.
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic         CLK,
  input  logic         RESET_,
  input  logic         tm_stb,
  input  logic         tm_clk,
  input  logic         dio_in,
  output logic         dio_out,
  output logic         dio_oe,
  input  logic [7:0]   keys,
  output logic [127:0] disp_ram,
  output logic         display_on,
  output logic [2:0]   brightness,
  output logic         frame_error
);
  localparam logic [7:0] SETTLE = 8'(SYNC_STAGES + 1);
  logic stb_s, stb_rise, stb_fall, clk_s, clk_rise, clk_fall, dio_s, dio_rise, dio_fall;
  logic unused_bits;
  tm1638_sync_edge #(.STAGES(SYNC_STAGES)) u_stb (.CLK(CLK), .RESET_(RESET_), .d(tm_stb),
    .q(stb_s), .rise(stb_rise), .fall(stb_fall));
  tm1638_sync_edge #(.STAGES(SYNC_STAGES)) u_clk (.CLK(CLK), .RESET_(RESET_), .d(tm_clk),
    .q(clk_s), .rise(clk_rise), .fall(clk_fall));
  tm1638_sync_edge #(.STAGES(SYNC_STAGES)) u_dio (.CLK(CLK), .RESET_(RESET_), .d(dio_in),
    .q(dio_s), .rise(dio_rise), .fall(dio_fall));
  state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d, bri_q, bri_d;
  logic [7:0] sh_q, sh_d, byte_q, byte_d, settle_q, settle_d;
  logic [3:0] addr_q, addr_d;
  logic [5:0] rd_cnt_q, rd_cnt_d;
  logic [15:0][7:0] ram_q, ram_d;
  logic byte_vld_q, byte_vld_d, rd_mode_q, rd_mode_d, fixed_q, fixed_d, on_q, on_d;
  logic oe_q, oe_d, out_q, out_d, ferr_q, ferr_d, armed_q, armed_d;
  logic settled, shifting;
  logic [31:0] kw;
  assign settled  = settle_q == SETTLE;
  assign shifting = !stb_s && clk_rise && (state_q == CMD || state_q == WDATA);
  assign kw       = key_word(keys);
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    addr_d     = addr_q;
    rd_mode_d  = rd_mode_q;
    fixed_d    = fixed_q;
    on_d       = on_q;
    bri_d      = bri_q;
    ram_d      = ram_q;
    oe_d       = oe_q;
    out_d      = out_q;
    rd_cnt_d   = rd_cnt_q;
    ferr_d     = 1'b0;
    settle_d   = settled ? settle_q : settle_q + 8'd1;
    armed_d    = armed_q | (settled & stb_s);
    if (stb_rise) begin
      ferr_d    = (bit_cnt_q != 3'd0) || (state_q == RDATA);
      state_d   = IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      out_d     = 1'b1;
    end else if (stb_fall) begin
      // Only a strobe seen going high after reset can open a frame.
      if (state_q == IDLE && armed_q) begin
        state_d   = CMD;
        bit_cnt_d = '0;
        rd_cnt_d  = '0;
      end
    end else begin
      if (byte_vld_q && state_q == CMD) begin
        case (byte_q[7:6])
          CMD_DATA: begin
            rd_mode_d = byte_q[READ_BIT];
            fixed_d   = byte_q[FIXED_BIT];
            state_d   = byte_q[READ_BIT] ? RDATA : SKIP;
          end
          CMD_DISP: begin
            on_d    = byte_q[ON_BIT];
            bri_d   = byte_q[2:0];
            state_d = SKIP;
          end
          CMD_ADDR: begin
            addr_d  = byte_q[3:0];
            state_d = WDATA;
          end
          default: begin
            ferr_d  = 1'b1;
            state_d = SKIP;
          end
        endcase
      end
      if (byte_vld_q && state_q == WDATA) begin
        ram_d[addr_q] = byte_q;
        addr_d        = fixed_q ? addr_q : addr_q + 4'd1;
      end
      if (shifting) begin
        sh_d      = {dio_s, sh_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        byte_vld_d = bit_cnt_q == 3'd7;
        byte_d    = bit_cnt_q == 3'd7 ? {dio_s, sh_q[7:1]} : byte_q;
      end
      if (!stb_s && state_q == RDATA && clk_fall && rd_cnt_q != 6'd32) begin
        oe_d     = 1'b1;
        out_d    = kw[rd_cnt_q[4:0]];
        rd_cnt_d = rd_cnt_q + 6'd1;
      end
      if (!stb_s && state_q == RDATA && clk_rise && rd_cnt_q == 6'd32) begin
        oe_d    = 1'b0;
        out_d   = 1'b1;
        state_d = SKIP;
      end
    end
  end
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      addr_q     <= '0;
      rd_mode_q  <= 1'b0;
      fixed_q    <= 1'b0;
      on_q       <= 1'b0;
      bri_q      <= '0;
      ram_q      <= '0;
      oe_q       <= 1'b0;
      out_q      <= 1'b1;
      rd_cnt_q   <= '0;
      ferr_q     <= 1'b0;
      settle_q   <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
      addr_q     <= addr_d;
      rd_mode_q  <= rd_mode_d;
      fixed_q    <= fixed_d;
      on_q       <= on_d;
      bri_q      <= bri_d;
      ram_q      <= ram_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
      rd_cnt_q   <= rd_cnt_d;
      ferr_q     <= ferr_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
    end
  end
  assign unused_bits = ^{clk_s, dio_rise, dio_fall, rd_mode_q};
  assign disp_ram    = ram_q;
  assign display_on  = on_q;
  assign brightness  = bri_q;
  assign dio_oe      = oe_q;
  assign dio_out     = out_q;
  assign frame_error = ferr_q;
endmodule

// File: tb/tb_tm1638_responder.sv
// tb_tm1638_responder: drives host-side TM1638 frames and checks RAM, display control,
// key readout and frame errors against expected values.
module tb_tm1638_responder;
  localparam int HALF = 8;
  logic CLK = 1'b0, RESET_ = 1'b0, tm_stb = 1'b1, tm_clk = 1'b1, dio_in = 1'b1;
  logic dio_out, dio_oe, display_on, frame_error;
  logic [7:0] keys = 8'h00;
  logic [127:0] disp_ram;
  logic [2:0] brightness;
  int checks = 0, errors = 0, ferr_cnt = 0;
  logic [7:0] exp_q[$];

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET_(RESET_), .tm_stb(tm_stb), .tm_clk(tm_clk), .dio_in(dio_in),
    .dio_out(dio_out), .dio_oe(dio_oe), .keys(keys), .disp_ram(disp_ram),
    .display_on(display_on), .brightness(brightness), .frame_error(frame_error));

  always #5 CLK = ~CLK;
  always @(posedge CLK) if (frame_error === 1'b1) ferr_cnt <= ferr_cnt + 1;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tm_clk = 1'b0;
      dio_in = b[i];
      cyc(HALF);
      tm_clk = 1'b1;
      cyc(HALF);
    end
  endtask

  task automatic frame(input logic [7:0] b0, b1, b2, b3, input int n);
    logic [7:0] bs[4];
    bs = '{b0, b1, b2, b3};
    tm_stb = 1'b0;
    cyc(HALF);
    for (int i = 0; i < n; i++) send_bits(bs[i], 8);
    cyc(HALF);
    tm_stb = 1'b1;
    cyc(2 * HALF);
  endtask

  task automatic check_ram(input string name, input logic [127:0] exp);
    checks++;
    if (disp_ram !== exp) begin
      errors++;
      $display("FAIL %s: disp_ram=%h expected %h", name, disp_ram, exp);
    end
  endtask

  task automatic check_ferr(input string name, input int base, input int exp_delta);
    checks++;
    if (ferr_cnt - base !== exp_delta) begin
      errors++;
      $display("FAIL %s: frame_error pulses=%0d expected %0d", name, ferr_cnt - base, exp_delta);
    end
  endtask

  task automatic test_reset();
    RESET_ = 1'b0;
    cyc(3);
    check_ram("reset_ram", '0);
    checks += 5;
    if (display_on !== 1'b0) begin errors++; $display("FAIL reset_on: got %b expected 0", display_on); end
    if (brightness !== 3'd0) begin errors++; $display("FAIL reset_bri: got %0d expected 0", brightness); end
    if (dio_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", dio_oe); end
    if (dio_out !== 1'b1) begin errors++; $display("FAIL reset_out: got %b expected 1", dio_out); end
    if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_error); end
    RESET_ = 1'b1;
    cyc(10);
  endtask

  task automatic test_write_auto();
    int base = ferr_cnt;
    frame(8'h40, 8'h00, 8'h00, 8'h00, 1);
    frame(8'hC0, 8'h3F, 8'h06, 8'h5B, 4);
    check_ram("write_auto", 128'h5B063F);
    check_ferr("write_auto_ferr", base, 0);
  endtask

  task automatic test_fixed_and_wrap();
    frame(8'h44, 8'h00, 8'h00, 8'h00, 1);
    frame(8'hCF, 8'h11, 8'h22, 8'h00, 3);
    check_ram("fixed", 128'h2200_0000_0000_0000_0000_0000_005B_063F);
    frame(8'h40, 8'h00, 8'h00, 8'h00, 1);
    frame(8'hCF, 8'hAA, 8'hBB, 8'h00, 3);
    check_ram("wrap", 128'hAA00_0000_0000_0000_0000_0000_005B_06BB);
  endtask

  task automatic test_read(input logic [7:0] k, input logic [31:0] exp_word);
    int base = ferr_cnt;
    logic [7:0] got, exp;
    logic oe_ok;
    keys = k;
    for (int b = 0; b < 4; b++) exp_q.push_back(exp_word[8*b +: 8]);
    tm_stb = 1'b0;
    cyc(HALF);
    send_bits(8'h42, 8);
    for (int b = 0; b < 4; b++) begin
      oe_ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
        tm_clk = 1'b0;
        cyc(HALF);
        got[i] = dio_out;
        oe_ok &= (dio_oe === 1'b1);
        tm_clk = 1'b1;
        cyc(HALF);
      end
      exp = exp_q.pop_front();
      checks += 2;
      if (got !== exp) begin errors++; $display("FAIL read_byte%0d: got %h expected %h", b, got, exp); end
      if (!oe_ok) begin errors++; $display("FAIL read_oe%0d: dio_oe dropped during byte, expected 1", b); end
    end
    checks++;
    if (dio_oe !== 1'b0) begin errors++; $display("FAIL read_oe_end: got %b expected 0", dio_oe); end
    tm_stb = 1'b1;
    cyc(2 * HALF);
    check_ferr("read_ferr", base, 0);
  endtask

  task automatic test_read_abort();
    int base = ferr_cnt;
    tm_stb = 1'b0;
    cyc(HALF);
    send_bits(8'h42, 8);
    send_bits(8'h00, 8);
    tm_stb = 1'b1;
    cyc(2 * HALF);
    checks++;
    if (dio_oe !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b expected 0", dio_oe); end
    check_ferr("abort_ferr", base, 1);
    frame(8'h40, 8'h00, 8'h00, 8'h00, 1);
  endtask

  task automatic test_display();
    logic [3:0] pats[3] = '{4'hF, 4'h0, 4'hA};
    for (int i = 0; i < 3; i++) begin
      frame({4'h8, pats[i]}, 8'h00, 8'h00, 8'h00, 1);
      checks += 2;
      if (display_on !== pats[i][3]) begin errors++; $display("FAIL disp_on_%0d: got %b expected %b", i, display_on, pats[i][3]); end
      if (brightness !== pats[i][2:0]) begin errors++; $display("FAIL disp_bri_%0d: got %0d expected %0d", i, brightness, pats[i][2:0]); end
    end
  endtask

  task automatic test_partial_and_bad_cmd();
    int base = ferr_cnt;
    tm_stb = 1'b0;
    cyc(HALF);
    send_bits(8'hC5, 8);
    send_bits(8'hFF, 5);
    cyc(HALF);
    tm_stb = 1'b1;
    cyc(2 * HALF);
    check_ferr("partial_ferr", base, 1);
    check_ram("partial_ram", 128'hAA00_0000_0000_0000_0000_0000_005B_06BB);
    base = ferr_cnt;
    frame(8'h3F, 8'h00, 8'h00, 8'h00, 1);
    check_ferr("bad_cmd_ferr", base, 1);
  endtask

  task automatic test_reset_mid_read();
    int base;
    keys = 8'hFF;
    tm_stb = 1'b0;
    cyc(HALF);
    send_bits(8'h42, 8);
    send_bits(8'h00, 3);
    tm_clk = 1'b0;
    cyc(HALF);
    checks++;
    if (dio_oe !== 1'b1) begin errors++; $display("FAIL mid_oe_before: got %b expected 1", dio_oe); end
    RESET_ = 1'b0;
    #1;
    checks++;
    if (dio_oe !== 1'b0) begin errors++; $display("FAIL mid_oe_reset: got %b expected 0", dio_oe); end
    cyc(2);
    RESET_ = 1'b1;
    cyc(HALF);
    tm_clk = 1'b1;
    cyc(HALF);
    base = ferr_cnt;
    tm_stb = 1'b1;
    cyc(2 * HALF);
    frame(8'hC1, 8'h77, 8'h00, 8'h00, 2);
    check_ram("after_reset_write", 128'h7700);
    check_ferr("after_reset_ferr", base, 0);
  endtask

  initial begin
    test_reset();
    test_write_auto();
    test_fixed_and_wrap();
    test_read(8'h81, 32'h10000001);
    test_read(8'h5A, 32'h01100110);
    test_read_abort();
    test_display();
    test_partial_and_bad_cmd();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
